uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with an integrated write FIFO: successor to the 8-bit single-byte buffered TX.
//  Host pushes words with a valid strobe. The block serialises them LSB-first (start, DBIT data, optional parity, stop) paced by the shared baud s_tick.
//  Sits between the CORDIC result/host logic and the board TX pin; frames go out back-to-back with no idle gap while the FIFO is non-empty.
// PARAMETERS
//  DBIT       8   data bits per frame (5..9)
//  OVERSAMPLE 16  s_tick pulses per start/data/parity bit
//  SB_TICK    16  s_tick pulses for stop period (16=1 stop, 24=1.5, 32=2)
//  FIFO_AW    4   FIFO address width; depth = 2**FIFO_AW
// PORTS
//  CLK         in   1          system clock, rising edge
//  RST         in   1          asynchronous reset, active-low
//  s_tick      in   1          baud oversample tick, one CLK wide
//  WR_EN       in   1          push DATAIN into FIFO
//  DATAIN      in   DBIT       word to transmit
//  PARITY_ODD  in   1          1=odd, 0=even parity (only with UART_TX_PARITY_EN)
//  FULL        out  1          FIFO full; push ignored
//  EMPTY       out  1          FIFO empty
//  LEVEL       out  FIFO_AW+1  FIFO occupancy 0..2**FIFO_AW
//  OVERRUN     out  1          1-cycle pulse when WR_EN asserted while FULL
//  BUSY        out  1          FSM not in IDLE
//  TX          out  1          serial line, idle high
//  TX_Done     out  1          1-cycle pulse at end of each frame's stop period
// BEHAVIOUR
//  Reset (RST=0, async): FSM=IDLE; FIFO pointers=0; TX=1; TX_Done=0; OVERRUN=0; BUSY=0; EMPTY=1; FULL=0; LEVEL=0.
//  Reset mid-frame: the frame is aborted, TX=1 immediately, and FIFO contents are discarded.
//  FIFO push: on WR_EN&&!FULL, DATAIN is written and LEVEL increments. On WR_EN&&FULL the data is dropped and OVERRUN pulses.
//  FIFO pop: happens only in IDLE when !EMPTY. The head is loaded into shift reg b_reg, the tick counter s=0, the bit counter n=0, and the FSM goes to START.
//  Same-cycle push+pop: LEVEL is unchanged. Push is judged on FULL before the pop.
//  No bypass: a push into an empty FIFO is popped at the earliest on the next cycle.
//  States: IDLE, START, DATA, PARITY, STOP. Counter s advances only on s_tick.
//   IDLE: TX=1.
//   START: TX=0. When s==OVERSAMPLE-1 on a tick: s=0, go to DATA.
//   DATA: TX=b_reg[0]. When s==OVERSAMPLE-1 on a tick: s=0, shift b_reg right. If n==DBIT-1, go to PARITY (feature on) or STOP; otherwise n++.
//   PARITY: TX = ^data ^ PARITY_ODD, using data latched at pop and PARITY_ODD sampled at pop. Lasts OVERSAMPLE ticks, then go to STOP.
//   STOP: TX=1. When s==SB_TICK-1 on a tick: TX_Done=1 for that cycle. If FIFO non-empty, pop the next word and go to START in the same cycle; otherwise go to IDLE.
//  Frame length in s_tick pulses = OVERSAMPLE*(1+DBIT[+1]) + SB_TICK.
//  TX is registered. The first START low appears the cycle after the pop.
//  s_tick is ignored in IDLE, and the counters do not run.
//  LEVEL, FULL and EMPTY are registered and consistent with each other every cycle. Pointers wrap modulo 2**FIFO_AW.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: the PARITY state exists and PARITY_ODD is a live port.
//  UART_TX_PARITY_EN undefined: no PARITY state; DATA goes directly to STOP; the PARITY_ODD port is kept but unused.
// STRUCTURE
//  Shared package uart_pkg: FSM state enum (IDLE/START/DATA/PARITY/STOP) and its encoding localparams.
//  One sub-module: uart_sync_fifo (width DBIT, depth 2**FIFO_AW, push/pop, FULL/EMPTY/LEVEL).
//  The FSM and shifter stay in this module.
// TESTING (DBIT=8, OVERSAMPLE=16, SB_TICK=16, FIFO_AW=4, s_tick every 4 CLK)
//  1. Push 0x55 once -> TX = 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each bit 16 ticks. One TX_Done pulse after 160 ticks. BUSY falls, EMPTY=1.
//  2. Push 0xA3,0x0F,0xFF back-to-back -> three frames with no idle gap between them; 3 TX_Done pulses spaced exactly 160 ticks apart.
//  3. Push 17 words while TX is stalled at the first frame -> FULL=1 once LEVEL=16; the 17th push gives an OVERRUN pulse; only 16 words are sent, in order.
//  4. Push while full in the same cycle as a STOP-end pop -> word dropped, OVERRUN=1, LEVEL goes 16->15.
//  5. Assert RST low during DATA bit 3 of 0x3C -> TX=1 immediately, LEVEL=0, no TX_Done. After release, a new 0x81 is transmitted correctly.
//  6. With UART_TX_PARITY_EN: 0x07 with PARITY_ODD=0 -> parity bit 1. 0x07 with PARITY_ODD=1 -> parity bit 0. Frame = 176 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding
// and a small helper used to size counters.
package uart_pkg;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_START  = 3'd1;
  localparam logic [2:0] ENC_DATA   = 3'd2;
  localparam logic [2:0] ENC_PARITY = 3'd3;
  localparam logic [2:0] ENC_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_START  = ENC_START,
    ST_DATA   = ENC_DATA,
    ST_PARITY = ENC_PARITY,
    ST_STOP   = ENC_STOP
  } tx_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags; the head word is
// presented combinationally on data_o whenever the FIFO is not empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Push is judged on the pre-pop FULL, so a full FIFO drops a same-cycle push.
  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // NOTE: default assignment first so no path leaves level_d unassigned (no latch).
  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == DEPTH_L);
      empty_q <= (level_d == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and flags alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO; frames go out back-to-back while words
// are queued. Define UART_TX_PARITY_EN to add a parity bit after the data bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               s_tick,
  input  logic               WR_EN,
  input  logic [DBIT-1:0]    DATAIN,
  input  logic               PARITY_ODD,
  output logic               FULL,
  output logic               EMPTY,
  output logic [FIFO_AW:0]   LEVEL,
  output logic               OVERRUN,
  output logic               BUSY,
  output logic               TX,
  output logic               TX_Done
);

  localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_e       state_q;
  logic [SW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] b_q;
  logic            tx_q, done_q, overrun_q;
  logic [DBIT-1:0] fifo_head;
  logic            fifo_empty, pop;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign pop = !fifo_empty &&
               ((state_q == ST_IDLE) ||
                (state_q == ST_STOP && s_tick && s_q == S_STOP_LAST));

  uart_sync_fifo #(.WIDTH(DBIT), .AW(FIFO_AW)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .push_i  (WR_EN),
    .data_i  (DATAIN),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (FULL),
    .empty_o (fifo_empty),
    .level_o (LEVEL)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      overrun_q <= WR_EN && FULL;
      case (state_q)
        ST_IDLE: ;
        ST_START: if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_q     <= '0;
            tx_q    <= b_q[0];
            state_q <= ST_DATA;
          end else s_q <= s_q + SW'(1);
        end
        ST_DATA: if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_q <= '0;
            b_q <= b_q >> 1;
            if (n_q == N_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= ST_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
`endif
            end else begin
              tx_q <= b_q[1];
              n_q  <= n_q + NW'(1);
            end
          end else s_q <= s_q + SW'(1);
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_q     <= '0;
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end else s_q <= s_q + SW'(1);
        end
`endif
        ST_STOP: if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_q     <= '0;
            done_q  <= 1'b1;
            tx_q    <= 1'b1;
            state_q <= ST_IDLE;
          end else s_q <= s_q + SW'(1);
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
      // A pop overrides the transition above: load the head and start a new frame.
      if (pop) begin
        b_q     <= fifo_head;
        s_q     <= '0;
        n_q     <= '0;
        tx_q    <= 1'b0;
        state_q <= ST_START;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^fifo_head ^ PARITY_ODD;
`endif
      end
    end
  end

  assign EMPTY   = fifo_empty;
  assign OVERRUN = overrun_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign TX      = tx_q;
  assign TX_Done = done_q;

endmodule
